// File: rtl/cu_done_aggregator.sv
// Multi-CU completion tracker: sums per-CU counts against a job total, reports the
// result to MMIO with a done/ack handshake, then issues a timed soft-reset pulse.
module cu_done_aggregator #(
  parameter int unsigned NUM_CU     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RESET_HOLD = 8
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    enabled_in,
  input  logic                    config_valid,
  input  logic [CNT_W-1:0]        expected_total,
  input  logic [NUM_CU-1:0]       cu_count_valid,
  input  logic [NUM_CU*CNT_W-1:0] cu_count,
  input  logic [NUM_CU-1:0]       cu_done_in,
  input  logic                    done_ack_in,
  output logic                    return_done_out,
  output logic [CNT_W-1:0]        return_total_out,
  output logic                    soft_reset_out,
  output logic                    busy_out,
  output logic                    overflow_error_out
);

  localparam int unsigned SUM_W = CNT_W + $clog2(NUM_CU) + 1;
  localparam int unsigned ACC_W = SUM_W + 2;
  localparam int unsigned CW    = $clog2(RESET_HOLD + 2);
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_REPORT,
    S_PULSE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [SUM_W-1:0]    sum1_q, sum1_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [NUM_CU-1:0]   mask_q, mask_d;
  logic                ret_done_q, ret_done_d;
  logic [CNT_W-1:0]    ret_total_q, ret_total_d;
  logic                soft_q, soft_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic [SUM_W-1:0]    lane_sum_c;
  logic                fin_c;
  logic [ACC_W-1:0]    sum_all_c;
  logic                sat_c;
  logic [CNT_W-1:0]    acc_sat_c;

  // Stage-1 operand: masked sum of the valid count lanes this cycle
  always_comb begin
    lane_sum_c = '0;
    for (int i = 0; i < NUM_CU; i++) begin
      if (cu_count_valid[i]) begin
        lane_sum_c = lane_sum_c + SUM_W'(cu_count[i*CNT_W +: CNT_W]);
      end
    end
  end

  // Stage-2 saturating add; the last DRAIN cycle also folds in that cycle's lanes
  // so every strobe seen during DRAIN lands in the frozen result.
  always_comb begin
    fin_c     = (state_q == S_DRAIN) && (cnt_q != '0);
    sum_all_c = ACC_W'(acc_q) + ACC_W'(sum1_q) + (fin_c ? ACC_W'(lane_sum_c) : ACC_W'(0));
    sat_c     = (sum_all_c > SAT_MAX);
    acc_sat_c = sat_c ? {CNT_W{1'b1}} : CNT_W'(sum_all_c);
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    sum1_d      = '0;
    acc_d       = acc_q;
    mask_d      = mask_q;
    ret_done_d  = ret_done_q;
    ret_total_d = ret_total_q;
    soft_d      = soft_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        ret_done_d = 1'b0;
        soft_d     = 1'b0;
        if (config_valid && enabled_in) begin
          state_d = S_RUN;
          total_d = expected_total;
          acc_d   = '0;
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!enabled_in) begin
          state_d = S_IDLE;
        end else begin
          sum1_d = lane_sum_c;
          acc_d  = acc_sat_c;
          if (sat_c) ovf_d = 1'b1;
          mask_d = mask_q | cu_done_in;
          if ((acc_q >= total_q) || (&mask_q)) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (!enabled_in) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sat_c;
          if (sat_c) ovf_d = 1'b1;
          if (cnt_q == '0) begin
            sum1_d = lane_sum_c;
            cnt_d  = CW'(1);
          end else begin
            state_d     = S_REPORT;
            ret_total_d = acc_sat_c;
            ret_done_d  = 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (!enabled_in) begin
          state_d    = S_IDLE;
          ret_done_d = 1'b0;
        end else if (done_ack_in) begin
          state_d    = S_PULSE;
          ret_done_d = 1'b0;
          soft_d     = 1'b1;
          cnt_d      = '0;
        end
      end
      S_PULSE: begin
        if (cnt_q == CW'(RESET_HOLD - 1)) begin
          state_d = S_IDLE;
          soft_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      total_q     <= '0;
      sum1_q      <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      ret_done_q  <= 1'b0;
      ret_total_q <= '0;
      soft_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      sum1_q      <= sum1_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      ret_done_q  <= ret_done_d;
      ret_total_q <= ret_total_d;
      soft_q      <= soft_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign return_done_out    = ret_done_q;
  assign return_total_out   = ret_total_q;
  assign soft_reset_out     = soft_q;
  assign busy_out           = busy_q;
  assign overflow_error_out = ovf_q;

endmodule

// File: tb/tb_cu_done_aggregator.sv
// Scoreboard bench for cu_done_aggregator: directed scenarios plus randomized jobs
// checked against a job-level sum/saturation model.
module tb_cu_done_aggregator;

  localparam int unsigned NUM_CU     = 4;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned RESET_HOLD = 8;
  localparam longint      MAXV       = 1023;

  logic                    clock;
  logic                    rst;
  logic                    enabled_in;
  logic                    config_valid;
  logic [CNT_W-1:0]        expected_total;
  logic [NUM_CU-1:0]       cu_count_valid;
  logic [NUM_CU*CNT_W-1:0] cu_count;
  logic [NUM_CU-1:0]       cu_done_in;
  logic                    done_ack_in;
  logic                    return_done_out;
  logic [CNT_W-1:0]        return_total_out;
  logic                    soft_reset_out;
  logic                    busy_out;
  logic                    overflow_error_out;

  cu_done_aggregator #(
    .NUM_CU(NUM_CU), .CNT_W(CNT_W), .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clock(clock), .rst(rst), .enabled_in(enabled_in), .config_valid(config_valid),
    .expected_total(expected_total), .cu_count_valid(cu_count_valid), .cu_count(cu_count),
    .cu_done_in(cu_done_in), .done_ack_in(done_ack_in), .return_done_out(return_done_out),
    .return_total_out(return_total_out), .soft_reset_out(soft_reset_out),
    .busy_out(busy_out), .overflow_error_out(overflow_error_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    longint total;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     pulse_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint job_sum  = 0;
  bit     ovf_m    = 1'b0;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each new report and on each completed soft-reset pulse
  initial begin
    bit   prev_done = 1'b0;
    bit   prev_soft = 1'b0;
    int   plen      = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (return_done_out && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_report: got total %0d, expected no report", return_total_out);
        end else begin
          e = exp_q.pop_front();
          check("report_total", longint'(return_total_out), e.total);
          check("report_overflow", longint'(overflow_error_out), longint'(e.ovf));
        end
      end
      if (soft_reset_out) begin
        plen++;
      end else if (prev_soft) begin
        if (pulse_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got length %0d, expected no pulse", plen);
        end else begin
          check("pulse_length", longint'(plen), longint'(pulse_q.pop_front()));
        end
        plen = 0;
      end
      prev_done = return_done_out;
      prev_soft = soft_reset_out;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    ovf_m = 1'b0;
  endtask

  task automatic start_job(input longint tot);
    expected_total = CNT_W'(tot);
    config_valid   = 1'b1;
    tick();
    config_valid = 1'b0;
    job_sum      = 0;
  endtask

  task automatic strobe(input logic [3:0] v, input int unsigned a, input int unsigned b,
                        input int unsigned c, input int unsigned d);
    cu_count_valid = v;
    cu_count       = {CNT_W'(d), CNT_W'(c), CNT_W'(b), CNT_W'(a)};
    if (v[0]) job_sum += a;
    if (v[1]) job_sum += b;
    if (v[2]) job_sum += c;
    if (v[3]) job_sum += d;
    tick();
    cu_count_valid = '0;
  endtask

  // Expected job result: every counted strobe summed, clipped to the counter range
  task automatic finish_job();
    exp_t e;
    if (job_sum > MAXV) ovf_m = 1'b1;
    e.total = (job_sum > MAXV) ? MAXV : job_sum;
    e.ovf   = ovf_m;
    exp_q.push_back(e);
  endtask

  task automatic wait_report();
    int n = 0;
    while (!return_done_out && n < 60) begin
      tick();
      n++;
    end
    check("report_seen", longint'(return_done_out), 1);
  endtask

  task automatic ack_job(input int plen);
    cu_count_valid = '0;
    done_ack_in    = 1'b1;
    tick();
    done_ack_in = 1'b0;
    pulse_q.push_back(plen);
    check("done_after_ack", longint'(return_done_out), 0);
    check("soft_after_ack", longint'(soft_reset_out), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 40) begin
      tick();
      n++;
    end
    check("back_to_idle", longint'(busy_out), 0);
    check("idle_soft_low", longint'(soft_reset_out), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int hits_done;
    int hits_soft;
    rst            = 1'b1;
    enabled_in     = 1'b0;
    config_valid   = 1'b0;
    expected_total = '0;
    cu_count_valid = '0;
    cu_count       = '0;
    cu_done_in     = '0;
    done_ack_in    = 1'b0;
    do_reset();
    enabled_in = 1'b1;

    check("rst_busy", longint'(busy_out), 0);
    check("rst_done", longint'(return_done_out), 0);
    check("rst_total", longint'(return_total_out), 0);
    check("rst_soft", longint'(soft_reset_out), 0);
    check("rst_overflow", longint'(overflow_error_out), 0);

    // Count-exit job: one strobe of 25 per CU, ack a few cycles after done
    start_job(100);
    check("run_busy", longint'(busy_out), 1);
    for (int i = 0; i < 4; i++) strobe(4'(1 << i), 25, 25, 25, 25);
    finish_job();
    wait_report();
    tick(); tick();
    ack_job(RESET_HOLD);
    wait_idle();

    // Done-mask exit well below the configured total
    start_job(1000);
    cu_done_in = 4'hF;
    strobe(4'hF, 10, 10, 10, 10);
    cu_done_in = '0;
    finish_job();
    wait_report();
    check("mask_exit_total", longint'(return_total_out), 40);
    ack_job(RESET_HOLD);
    wait_idle();

    // Zero total reports immediately with nothing counted
    start_job(0);
    finish_job();
    wait_report();
    ack_job(RESET_HOLD);
    wait_idle();

    // Ack in RUN and config in REPORT are both ignored
    start_job(100);
    done_ack_in = 1'b1;
    tick();
    done_ack_in = 1'b0;
    strobe(4'hF, 25, 25, 25, 25);
    finish_job();
    wait_report();
    expected_total = CNT_W'(7);
    config_valid   = 1'b1;
    tick();
    config_valid = 1'b0;
    check("cfg_in_report_done", longint'(return_done_out), 1);
    check("cfg_in_report_total", longint'(return_total_out), 100);
    check("cfg_in_report_busy", longint'(busy_out), 1);
    ack_job(RESET_HOLD);
    wait_idle();

    // Abort in RUN: no report, no pulse
    start_job(200);
    strobe(4'b0011, 25, 25, 0, 0);
    tick(); tick(); tick();
    enabled_in = 1'b0;
    tick();
    check("abort_busy", longint'(busy_out), 0);
    enabled_in = 1'b1;
    hits_done  = 0;
    hits_soft  = 0;
    for (int i = 0; i < 12; i++) begin
      if (return_done_out) hits_done++;
      if (soft_reset_out) hits_soft++;
      tick();
    end
    check("abort_no_report", longint'(hits_done), 0);
    check("abort_no_pulse", longint'(hits_soft), 0);

    // Saturation, then the flag persists through the next job
    start_job(1023);
    strobe(4'b0011, 800, 800, 0, 0);
    finish_job();
    wait_report();
    check("sat_overflow", longint'(overflow_error_out), 1);
    ack_job(RESET_HOLD);
    wait_idle();
    start_job(100);
    strobe(4'hF, 25, 25, 25, 25);
    finish_job();
    wait_report();
    ack_job(RESET_HOLD);
    wait_idle();
    check("overflow_sticky", longint'(overflow_error_out), 1);

    // Reset on the third pulse cycle cuts the pulse and clears everything
    start_job(50);
    strobe(4'b0001, 50, 0, 0, 0);
    finish_job();
    wait_report();
    ack_job(3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_soft", longint'(soft_reset_out), 0);
    check("midrst_busy", longint'(busy_out), 0);
    check("midrst_total", longint'(return_total_out), 0);
    check("midrst_overflow", longint'(overflow_error_out), 0);
    rst   = 1'b0;
    ovf_m = 1'b0;
    tick();

    // Randomized jobs, each ending by count crossing or by the full done mask
    for (int j = 0; j < 24; j++) begin
      if ($urandom_range(0, 1) == 0) begin
        longint tot = longint'($urandom_range(1, 600));
        start_job(tot);
        cu_done_in = 4'($urandom) & 4'b1110;
        for (int k = 0; k < 100 && job_sum < tot; k++) begin
          strobe(4'($urandom_range(1, 15)), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
          repeat ($urandom_range(0, 2)) tick();
        end
      end else begin
        int ns = $urandom_range(1, 6);
        start_job(longint'($urandom_range(900, 1023)));
        cu_done_in = 4'($urandom) & 4'b0111;
        for (int k = 0; k < ns; k++) begin
          strobe(4'($urandom), $urandom_range(0, 30), $urandom_range(0, 30),
                 $urandom_range(0, 30), $urandom_range(0, 30));
          repeat ($urandom_range(0, 2)) tick();
        end
        cu_done_in = 4'hF;
        strobe(4'($urandom), $urandom_range(0, 30), $urandom_range(0, 30),
               $urandom_range(0, 30), $urandom_range(0, 30));
      end
      finish_job();
      wait_report();
      cu_done_in = '0;
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        cu_count_valid = 4'($urandom);
        cu_count       = NUM_CU*CNT_W'({$urandom, $urandom});
        tick();
      end
      ack_job(RESET_HOLD);
      wait_idle();
    end

    tick(); tick(); tick();
    check("reports_drained", longint'(exp_q.size()), 0);
    check("pulses_drained", longint'(pulse_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
